sky130_ef_sc_hd__fill_segmenter: RTL
====================================

# sky130_ef_sc_hd__fill_segmenter

Sequential decoder that turns a requested filler gap width, in placement sites, into an ordered stream of filler/decap cell pieces. It supports a full-decap mode and a reduced-decap mode. In reduced-decap mode each 12-site chunk is expanded into the decap_6 + fill_4 + fill_2 composite. It sits between the row-gap producer in the physical-fill flow model and the cell-emission consumer, with a valid/ready handshake on both sides. Power pins VPWR, VGND, VPB and VNB are present under USE_POWER_PINS, as supplies otherwise, and have no logical function.

## Interface
- WIDTH_BITS, 8: width of the gap-width input and the piece counter.
- CLK  input  1  rising-edge clock.
- RESET_B  input  1  asynchronous active-low reset.
- in_valid  input  1  gap request valid.
- in_ready  output  1  block can accept a request; high only in IDLE.
- in_width  input  WIDTH_BITS  gap width in sites; 0 is legal.
- in_lowdecap  input  1  1 = reduced-decap mode, 0 = full-decap mode.
- out_valid  output  1  piece valid.
- out_ready  input  1  consumer accepts the piece.
- out_decap  output  1  1 = decap cell, 0 = fill cell.
- out_width  output  4  piece width in sites, 1..12.
- done  output  1  one-cycle pulse when a request completes.
- done_count  output  WIDTH_BITS  number of pieces emitted for the completed request; valid while done=1, held otherwise.

## Operation
- States: IDLE, EMIT, DONE.
- Registers:
  - rem: sites remaining, WIDTH_BITS wide.
  - mode: latched in_lowdecap.
  - sub: 2-bit composite phase, 0..2.
  - cnt: pieces emitted, WIDTH_BITS wide.
- IDLE:
  - in_ready=1.
  - On in_valid: latch in_width into rem, latch mode, clear sub and cnt.
  - If in_width==0, go to DONE; otherwise go to EMIT.
- EMIT: out_valid=1. The piece is a pure function of rem, mode and sub:
  - rem>=12, mode=0: decap 12.
  - rem>=12, mode=1: sub=0 gives decap 6, sub=1 gives fill 4, sub=2 gives fill 2.
  - rem<12: greedy largest of decap 8, decap 6, decap 4, decap 3, fill 2, fill 1 that is <= rem. Examples: 11 gives 8 then 3; 7 gives 6 then 1; 5 gives 4 then 1.
- On out_valid & out_ready:
  - rem -= out_width; cnt += 1.
  - In the mode=1 composite, sub advances 0 to 1 to 2 and wraps to 0 after the fill 2 piece.
  - If rem reaches 0, go to DONE.
- DONE:
  - done=1 for exactly one cycle; done_count=cnt.
  - Always return to IDLE the next cycle.
- Piece widths within a request always sum exactly to in_width. rem never underflows.
- in_width, in_lowdecap and in_valid are ignored outside IDLE.
- Reset mid-operation:
  - Everything returns to IDLE; the in-flight request is discarded.
  - No done pulse is generated for it.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_decap=0, out_width=0, done=0, done_count=0, rem=0, cnt=0, sub=0.
- All outputs come from registers or decode only state registers. There is no combinational path from out_ready or in_valid to any output.
- Request accepted at edge T:
  - in_width>0: first out_valid=1 in cycle T+1.
  - in_width==0: done=1 in cycle T+1, out_valid never asserts.
- Back-to-back handshakes emit one piece per cycle, with no bubbles between pieces.
- Backpressure: while out_valid=1 and out_ready=0, out_decap and out_width hold stable.
- Last piece handshake at edge E: out_valid=0 and done=1 in cycle E+1. in_ready=1 in cycle E+2.
- Minimum request-to-request spacing: pieces + 2 cycles.

## Test plan
- Full-decap single chunk: in_width=12, lowdecap=0, out_ready=1.
  - Required: one piece, decap 12, in cycle T+1; done with count 1 in T+2.
- Reduced-decap single chunk: in_width=12, lowdecap=1.
  - Required: decap 6, fill 4, fill 2 on consecutive cycles; done_count=3.
- Greedy remainder: in_width=29, lowdecap=0.
  - Required: decap 12, decap 12, decap 4, fill 1; done_count=4; widths sum to 29.
- Zero width and back-to-back requests:
  - in_width=0 is accepted: no out_valid, done with count 0 in T+1, in_ready back high in T+2.
  - A second request of 2 then yields a single fill 2.
- Backpressure: in_width=11, out_ready held low 5 cycles, then high.
  - Required: decap 8 holds stable throughout the stall, then decap 3 follows; done_count=2.
- Reset mid-op: in_width=36, lowdecap=1, RESET_B pulsed low after the second piece.
  - Required: all outputs immediately at reset values; no done pulse.
  - A new request of 12 after reset produces the fresh sequence decap 6, fill 4, fill 2.

Source files
------------

// File: rtl/sky130_ef_sc_hd__fill_segmenter.sv
// sky130_ef_sc_hd__fill_segmenter
// Splits a requested filler gap (in placement sites) into an ordered stream of
// filler/decap pieces. In full-decap mode each 12-site chunk is one decap_12.
// In reduced-decap mode each chunk becomes decap_6 + fill_4 + fill_2. Any tail
// shorter than 12 sites is covered greedily. Both sides use valid/ready.
`timescale 1ns/1ps

module sky130_ef_sc_hd__fill_segmenter #(
    parameter int WIDTH_BITS = 8
) (
`ifdef USE_POWER_PINS
    inout  wire                    VPWR,
    inout  wire                    VGND,
    inout  wire                    VPB,
    inout  wire                    VNB,
`endif
    input  logic                   CLK,
    input  logic                   RESET_B,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH_BITS-1:0]  in_width,
    input  logic                   in_lowdecap,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_decap,
    output logic [3:0]             out_width,
    output logic                   done,
    output logic [WIDTH_BITS-1:0]  done_count
);

`ifndef USE_POWER_PINS
    supply1 VPWR;
    supply0 VGND;
    supply1 VPB;
    supply0 VNB;
`endif

    // Power pins carry no logical function; fold them into one sink net.
    wire w_unused_pwr = VPWR & VGND & VPB & VNB;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH_BITS-1:0] CHUNK = WIDTH_BITS'(12);

    state_t                r_state;
    logic [WIDTH_BITS-1:0] r_rem;
    logic                  r_mode;
    logic [1:0]            r_sub;
    logic [WIDTH_BITS-1:0] r_cnt;
    logic                  r_done;
    logic [WIDTH_BITS-1:0] r_done_count;

    logic                  w_composite;
    logic                  w_piece_decap;
    logic [3:0]            w_piece_width;
    logic                  w_emit;
    logic                  w_handshake;
    logic [WIDTH_BITS-1:0] w_rem_next;

    // A reduced-decap chunk stays in composite mode until its fill_2 is out,
    // even though rem drops below 12 after the first piece (e.g. 12 -> 6).
    assign w_composite = r_mode && ((r_sub != 2'd0) || (r_rem >= CHUNK));

    // Decode the current piece purely from rem, mode and sub.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        w_piece_decap = 1'b0;
        w_piece_width = 4'd0;
        if (w_composite) begin
            case (r_sub)
                2'd0:    begin w_piece_decap = 1'b1; w_piece_width = 4'd6; end
                2'd1:    begin w_piece_decap = 1'b0; w_piece_width = 4'd4; end
                default: begin w_piece_decap = 1'b0; w_piece_width = 4'd2; end
            endcase
        end else if (r_rem >= CHUNK) begin
            w_piece_decap = 1'b1;
            w_piece_width = 4'd12;
        end else if (r_rem >= WIDTH_BITS'(8)) begin
            w_piece_decap = 1'b1;
            w_piece_width = 4'd8;
        end else if (r_rem >= WIDTH_BITS'(6)) begin
            w_piece_decap = 1'b1;
            w_piece_width = 4'd6;
        end else if (r_rem >= WIDTH_BITS'(4)) begin
            w_piece_decap = 1'b1;
            w_piece_width = 4'd4;
        end else if (r_rem >= WIDTH_BITS'(3)) begin
            w_piece_decap = 1'b1;
            w_piece_width = 4'd3;
        end else if (r_rem >= WIDTH_BITS'(2)) begin
            w_piece_decap = 1'b0;
            w_piece_width = 4'd2;
        end else if (r_rem >= WIDTH_BITS'(1)) begin
            w_piece_decap = 1'b0;
            w_piece_width = 4'd1;
        end
    end

    assign w_emit      = (r_state == S_EMIT);
    assign w_handshake = w_emit && out_ready;
    assign w_rem_next  = r_rem - WIDTH_BITS'(w_piece_width);

    // Outputs decode registers only; no combinational path from out_ready or in_valid.
    assign in_ready   = (r_state == S_IDLE);
    assign out_valid  = w_emit;
    assign out_decap  = w_emit & w_piece_decap;
    assign out_width  = w_emit ? w_piece_width : 4'd0;
    assign done       = r_done;
    assign done_count = r_done_count;

    // Request FSM: accept in IDLE, stream pieces in EMIT, pulse done in DONE.
    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            r_state      <= S_IDLE;
            r_rem        <= '0;
            r_mode       <= 1'b0;
            r_sub        <= 2'd0;
            r_cnt        <= '0;
            r_done       <= 1'b0;
            r_done_count <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_rem  <= in_width;
                        r_mode <= in_lowdecap;
                        r_sub  <= 2'd0;
                        r_cnt  <= '0;
                        if (in_width == '0) begin
                            r_state      <= S_DONE;
                            r_done       <= 1'b1;
                            r_done_count <= '0;
                        end else begin
                            r_state <= S_EMIT;
                        end
                    end
                end
                S_EMIT: begin
                    if (w_handshake) begin
                        r_rem <= w_rem_next;
                        r_cnt <= r_cnt + WIDTH_BITS'(1);
                        if (w_composite) begin
                            r_sub <= (r_sub == 2'd2) ? 2'd0 : r_sub + 2'd1;
                        end
                        if (w_rem_next == '0) begin
                            r_state      <= S_DONE;
                            r_done       <= 1'b1;
                            r_done_count <= r_cnt + WIDTH_BITS'(1);
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
